// File: rtl/dot_prod_pkg.sv
// dot_prod_pkg: shared state encoding and constants for the dot-product sequencer.
package dot_prod_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, DONE} state_t;
    localparam int PIPE_LAT_DEF = 4;
    localparam int MAC_W = 32;
endpackage

// File: rtl/dot_prod_seq_if.sv
// dot_prod_seq_if: job, operand-memory, MAC and result signals of the sequencer.
// Optional abort input present when DOT_PROD_SEQ_ABORT_EN is defined.
interface dot_prod_seq_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int LEN_W = 8
);
    logic start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0] len;
    logic busy;
    logic rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic signed [DATA_W-1:0] rd_data_a, rd_data_b;
    logic signed [DATA_W-1:0] mac_a, mac_b;
    logic mac_en, mac_rst;
    logic signed [dot_prod_pkg::MAC_W-1:0] mac_acc;
    logic signed [dot_prod_pkg::MAC_W-1:0] result;
    logic result_valid, result_ready;
`ifdef DOT_PROD_SEQ_ABORT_EN
    logic abort;
`endif
    modport slave (
`ifdef DOT_PROD_SEQ_ABORT_EN
        input abort,
`endif
        input start, base_addr, len, rd_data_a, rd_data_b, mac_acc, result_ready,
        output busy, rd_en, rd_addr, mac_a, mac_b, mac_en, mac_rst, result, result_valid
    );
    modport master (
`ifdef DOT_PROD_SEQ_ABORT_EN
        output abort,
`endif
        output start, base_addr, len, rd_data_a, rd_data_b, mac_acc, result_ready,
        input busy, rd_en, rd_addr, mac_a, mac_b, mac_en, mac_rst, result, result_valid
    );
endinterface

// File: rtl/dot_prod_addr_gen.sv
// dot_prod_addr_gen: operand address counter and remaining-element down-counter.
module dot_prod_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o,
    output logic              empty_o
);
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    always_comb begin
        addr_d = load_i ? base_i : step_i ? addr_q + 1'b1 : addr_q;
        cnt_d = load_i ? len_i : step_i ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            addr_q <= '0;
            cnt_q <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q <= cnt_d;
        end

    assign addr_o = addr_q;
    assign last_o = cnt_q == LEN_W'(1);
    assign empty_o = cnt_q == '0;
endmodule

// File: rtl/dot_prod_seq.sv
// dot_prod_seq: streams operand pairs from memory into an external pipelined MAC and captures the sum.
// Optional abort input enabled by DOT_PROD_SEQ_ABORT_EN.
module dot_prod_seq import dot_prod_pkg::*; #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int LEN_W = 8,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input logic clk,
    input logic rst_n,
    dot_prod_seq_if.slave bus
);
    localparam int DW = $clog2(PIPE_LAT + 2);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(PIPE_LAT);

    state_t state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic issue_vld_q, abort_req, load, last, empty;
    logic signed [MAC_W-1:0] result_q;

`ifdef DOT_PROD_SEQ_ABORT_EN
    assign abort_req = bus.abort && state_q != IDLE;
`else
    assign abort_req = 1'b0;
`endif
    assign load = state_q == IDLE && bus.start;

    dot_prod_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
        .clk(clk),
        .rst_n(rst_n),
        .load_i(load),
        .step_i(state_q == FETCH),
        .base_i(bus.base_addr),
        .len_i(bus.len),
        .addr_o(bus.rd_addr),
        .last_o(last),
        .empty_o(empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = bus.start ? CLEAR : IDLE;
            CLEAR:   state_d = empty ? DRAIN : FETCH;
            FETCH:   state_d = last ? DRAIN : FETCH;
            DRAIN:   state_d = drain_q == '0 ? DONE : DRAIN;
            DONE:    state_d = bus.result_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (abort_req) state_d = IDLE;
        drain_d = state_q == DRAIN ? drain_q - 1'b1 : DRAIN_INIT;
    end

    // Last operand reaches the MAC in the first DRAIN cycle; its sum is visible PIPE_LAT cycles later.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            drain_q <= DRAIN_INIT;
            issue_vld_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            issue_vld_q <= state_q == FETCH;
            if (state_q == DRAIN && drain_q == '0) result_q <= bus.mac_acc;
        end

    assign bus.busy = state_q != IDLE;
    assign bus.rd_en = state_q == FETCH;
    assign bus.mac_en = state_q inside {CLEAR, FETCH, DRAIN};
    assign bus.mac_rst = !rst_n || state_q == CLEAR || abort_req;
    assign bus.mac_a = issue_vld_q ? bus.rd_data_a : {DATA_W{1'b0}};
    assign bus.mac_b = issue_vld_q ? bus.rd_data_b : {DATA_W{1'b0}};
    assign bus.result = result_q;
    assign bus.result_valid = state_q == DONE;
endmodule

// File: tb/tb_dot_prod_seq.sv
// tb_dot_prod_seq: table-driven check of dot_prod_seq with operand memory and pipelined MAC models.
// Exercises the abort input when DOT_PROD_SEQ_ABORT_EN is defined.
module tb_dot_prod_seq;
    localparam int PL = 4;

    typedef struct {
        int base;
        int len;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        int res;
        int lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic signed [15:0] mem_a [1024];
    logic signed [15:0] mem_b [1024];
    int addr_log [$];
    logic signed [31:0] pipe [PL-1];
    logic signed [31:0] acc;
    vec_t vecs [6];

    dot_prod_seq_if #(.DATA_W(16), .ADDR_W(10), .LEN_W(8)) bus ();

    dot_prod_seq #(.DATA_W(16), .ADDR_W(10), .LEN_W(8), .PIPE_LAT(PL)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic signed [31:0] term(input logic signed [15:0] a, input logic signed [15:0] b);
        logic signed [31:0] p;
        p = a * b;
        return {{16{p[23]}}, p[23:8]};
    endfunction

    function automatic logic [3:0][15:0] pk(input int x0 = 0, input int x1 = 0, input int x2 = 0, input int x3 = 0);
        logic [3:0][15:0] r;
        r[0] = x0[15:0];
        r[1] = x1[15:0];
        r[2] = x2[15:0];
        r[3] = x3[15:0];
        return r;
    endfunction

    // Operand memory: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data_a <= mem_a[bus.rd_addr];
            bus.rd_data_b <= mem_b[bus.rd_addr];
            addr_log.push_back(int'(bus.rd_addr));
        end else begin
            bus.rd_data_a <= '0;
            bus.rd_data_b <= '0;
        end
    end

    // MAC: operands on inputs show up in acc PL cycles later.
    always @(posedge clk) begin
        if (bus.mac_rst) begin
            for (int i = 0; i < PL - 1; i++) pipe[i] <= '0;
            acc <= '0;
        end else if (bus.mac_en) begin
            pipe[0] <= term(bus.mac_a, bus.mac_b);
            for (int i = 1; i < PL - 1; i++) pipe[i] <= pipe[i-1];
            acc <= acc + pipe[PL-2];
        end
    end
    assign bus.mac_acc = acc;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            bus.start = 1'b0;
        end while (!bus.result_valid && cyc < 200);
    endtask

    task automatic launch(input int base, input int len);
        @(negedge clk);
        bus.base_addr = base[9:0];
        bus.len = len[7:0];
        bus.start = 1'b1;
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int cyc;
        for (int i = 0; i < v.len; i++) begin
            mem_a[(v.base + i) % 1024] = v.a[i];
            mem_b[(v.base + i) % 1024] = v.b[i];
        end
        addr_log.delete();
        launch(v.base, v.len);
        wait_valid(cyc);
        chk({tag, " latency"}, cyc, v.lat);
        chk({tag, " result"}, bus.result, v.res);
        chk({tag, " reads"}, addr_log.size(), v.len);
        for (int i = 0; i < v.len && i < addr_log.size(); i++)
            chk($sformatf("%s addr%0d", tag, i), addr_log[i], (v.base + i) % 1024);
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        chk({tag, " idle"}, bus.busy, 0);
    endtask

    task automatic interrupted_job(input bit use_abort, input string tag);
        int seen;
        launch(20, 4);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk({tag, " fetch2 rd_en"}, bus.rd_en, 1);
        chk({tag, " fetch2 addr"}, bus.rd_addr, 22);
        if (use_abort) begin
`ifdef DOT_PROD_SEQ_ABORT_EN
            bus.abort = 1'b1;
            #1;
            chk({tag, " mac_rst pulse"}, bus.mac_rst, 1);
            @(negedge clk);
            bus.abort = 1'b0;
`endif
        end else begin
            rst_n = 1'b0;
            #1;
            chk({tag, " busy"}, bus.busy, 0);
            chk({tag, " rd_en"}, bus.rd_en, 0);
            chk({tag, " mac_rst"}, bus.mac_rst, 1);
            chk({tag, " mac_a"}, bus.mac_a, 0);
            @(negedge clk);
            rst_n = 1'b1;
        end
        chk({tag, " idle"}, bus.busy, 0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            seen += int'(bus.result_valid);
        end
        chk({tag, " no result"}, seen, 0);
        run_job(vecs[2], {tag, " next job"});
    endtask

    initial begin
        int cyc;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.len = '0;
        bus.result_ready = 1'b0;
`ifdef DOT_PROD_SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        vecs[0] = '{0, 3, pk(256, 256, 256), pk(512, 512, 512), 1536, 10};
        vecs[1] = '{10, 2, pk(-256, 256), pk(256, 256), 0, 9};
        vecs[2] = '{10, 1, pk(256), pk(256), 256, 8};
        vecs[3] = '{0, 0, pk(), pk(), 0, 7};
        vecs[4] = '{1022, 4, pk(512, -768, 1024, 256), pk(256, 256, -512, 1280), -1024, 11};
        vecs[5] = '{500, 3, pk(3, 1000, 32767), pk(-100, 1000, 32767), 3648, 10};

        #12;
        chk("rst busy", bus.busy, 0);
        chk("rst rd_en", bus.rd_en, 0);
        chk("rst mac_en", bus.mac_en, 0);
        chk("rst mac_rst", bus.mac_rst, 1);
        chk("rst valid", bus.result_valid, 0);
        chk("rst rd_addr", bus.rd_addr, 0);
        chk("rst result", bus.result, 0);
        chk("rst mac_a", bus.mac_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) run_job(vecs[k], $sformatf("vec%0d", k));

        // Result must stay put while the consumer stalls; start is ignored in DONE.
        mem_a[40] = 16'sd768;
        mem_b[40] = 16'sd512;
        launch(40, 1);
        wait_valid(cyc);
        chk("hold latency", cyc, 8);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold result%0d", k), bus.result, 1536);
            chk($sformatf("hold valid%0d", k), bus.result_valid, 1);
            bus.start = (k == 2);
            @(posedge clk);
            @(negedge clk);
        end
        bus.start = 1'b1;
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.result_ready = 1'b0;
        chk("accept idle", bus.busy, 0);
        @(negedge clk);
        chk("accept no restart", bus.busy, 0);

        interrupted_job(1'b0, "reset");
`ifdef DOT_PROD_SEQ_ABORT_EN
        interrupted_job(1'b1, "abort");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
